// File: rtl/replacement_algorithm_pkg.sv
// Shared helpers for cache replacement blocks: index width mapping, age type, reset ages.
// Pure types and constant functions; no logic, no latency.
package replacement_algorithm_pkg;

  localparam int MAX_COUNTER_WIDTH = 8;

  typedef logic [MAX_COUNTER_WIDTH-1:0] age_t;

  function automatic int counterWidth(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Reset ordering makes line 0 the first victim, so an empty set fills 0,1,2,...
  function automatic age_t resetAge(input int index, input int n);
    return age_t'(n - 1 - index);
  endfunction

endpackage

// File: rtl/lru_replacement_unit_if.sv
// Replacement-algorithm link between cache controller (master) and LRU tracker (slave).
// Notifications are single-cycle strobes; the victim index is a level, no backpressure.
interface lru_replacement_unit_if #(
  parameter int COUNTER_WIDTH = 2
);
  logic                     accessEnable;
  logic                     invalidateEnable;
  logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine;
  logic [COUNTER_WIDTH-1:0] replacementCacheLine;

  modport master (
    output accessEnable,
    output invalidateEnable,
    output lastAccessedCacheLine,
    input  replacementCacheLine
  );

  modport slave (
    input  accessEnable,
    input  invalidateEnable,
    input  lastAccessedCacheLine,
    output replacementCacheLine
  );
endinterface

// File: rtl/lru_age_cell.sv
// Age register for one cache line; moves relative to the broadcast age of the touched line.
// Latency 1 (updates on the sampling edge); no backpressure, every strobe is consumed.
module lru_age_cell
  import replacement_algorithm_pkg::*;
#(
  parameter int NUMBER_OF_CACHE_LINES = 4,
  parameter int COUNTER_WIDTH         = counterWidth(NUMBER_OF_CACHE_LINES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] own_index,
  input  logic [COUNTER_WIDTH-1:0] reset_age,
  input  logic                     accessEnable,
  input  logic                     invalidateEnable,
  input  logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine,
  input  logic [COUNTER_WIDTH-1:0] target_age,
  output logic [COUNTER_WIDTH-1:0] age,
  output logic                     isLru
);
  localparam logic [COUNTER_WIDTH-1:0] AGE_MAX = COUNTER_WIDTH'(NUMBER_OF_CACHE_LINES - 1);

  logic hit;
  assign hit   = (lastAccessedCacheLine == own_index);
  assign isLru = (age == AGE_MAX);

  // Only ages strictly between the target and the end move, so no counter can wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      age <= reset_age;
    end else if (accessEnable) begin
      if (hit)                    age <= '0;
      else if (age < target_age)  age <= age + COUNTER_WIDTH'(1);
    end else if (invalidateEnable) begin
      if (hit)                    age <= AGE_MAX;
      else if (age > target_age)  age <= age - COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lru_replacement_unit.sv
// True-LRU victim tracker for one cache set; victim decoded from registered ages only.
// Latency 1 from notification to victim update; no backpressure.
module lru_replacement_unit
  import replacement_algorithm_pkg::*;
#(
  parameter int NUMBER_OF_CACHE_LINES = 4,
  parameter int COUNTER_WIDTH         = counterWidth(NUMBER_OF_CACHE_LINES)
) (
  input  logic                  clock,
  input  logic                  reset,
  lru_replacement_unit_if.slave rif
);
  logic [COUNTER_WIDTH-1:0]         ages [NUMBER_OF_CACHE_LINES];
  logic [NUMBER_OF_CACHE_LINES-1:0] is_lru;
  logic [COUNTER_WIDTH-1:0]         target_age;
  logic [COUNTER_WIDTH-1:0]         victim;

  assign target_age = ages[rif.lastAccessedCacheLine];

  for (genvar i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin : g_cell
    lru_age_cell #(
      .NUMBER_OF_CACHE_LINES (NUMBER_OF_CACHE_LINES),
      .COUNTER_WIDTH         (COUNTER_WIDTH)
    ) u_cell (
      .clock                 (clock),
      .reset                 (reset),
      .own_index             (COUNTER_WIDTH'(i)),
      .reset_age             (COUNTER_WIDTH'(resetAge(i, NUMBER_OF_CACHE_LINES))),
      .accessEnable          (rif.accessEnable),
      .invalidateEnable      (rif.invalidateEnable),
      .lastAccessedCacheLine (rif.lastAccessedCacheLine),
      .target_age            (target_age),
      .age                   (ages[i]),
      .isLru                 (is_lru[i])
    );
  end

  // is_lru is one-hot by construction, so OR-ing indices is a valid encoder.
  always_comb begin
    victim = '0;
    for (int i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
      if (is_lru[i]) victim = victim | COUNTER_WIDTH'(i);
    end
  end

  assign rif.replacementCacheLine = victim;

`ifndef SYNTHESIS
  logic [NUMBER_OF_CACHE_LINES-1:0] age_seen;

  always_comb begin
    age_seen = '0;
    for (int i = 0; i < NUMBER_OF_CACHE_LINES; i++) age_seen[ages[i]] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) assert ((&age_seen) && $onehot(is_lru));
  end
`endif

endmodule
